// File: rtl/fifo_n.sv
// fifo_n: parametrised synchronous FIFO using all DEPTH slots, with occupancy and almost-full status.
// Optional macro FIFO_N_FULL_PASS_EN lets an enqueue fire while full when a dequeue fires in the same cycle.
module fifo_n #(
  parameter int WIDTH       = 96,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         in_enq__ENA,
  input  logic [WIDTH-1:0]             in_enq_v,
  output logic                         in_enq__RDY,
  input  logic                         out_deq__ENA,
  output logic                         out_deq__RDY,
  output logic [WIDTH-1:0]             out_first,
  output logic                         out_first__RDY,
  output logic [$clog2(DEPTH+1)-1:0]   status_count,
  output logic                         status_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rindex;
  logic [AW-1:0]    windex;
  logic [CW-1:0]    count;
  logic             enq_fire;
  logic             deq_fire;

  // Handshake: a method fires in a cycle where its ENA and RDY are both high at the
  // rising edge; an ENA with RDY low is silently ignored. RDY never waits on ENA,
  // except the optional full-pass path from out_deq__ENA to in_enq__RDY.
  assign out_deq__RDY   = (count != '0);
  assign out_first__RDY = (count != '0);
`ifdef FIFO_N_FULL_PASS_EN
  assign in_enq__RDY    = (count != FULL_CNT) | out_deq__ENA;
`else
  assign in_enq__RDY    = (count != FULL_CNT);
`endif

  assign enq_fire = in_enq__ENA & in_enq__RDY;
  assign deq_fire = out_deq__ENA & out_deq__RDY;

  assign out_first    = mem[rindex];
  assign status_count = count;
  assign status_afull = (count >= AFULL_CNT);

  // When full-pass fires, windex == rindex: the head is read combinationally
  // this cycle and the same slot is overwritten at the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rindex <= '0;
      windex <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq_fire) begin
        mem[windex] <= in_enq_v;
        windex      <= windex + 1'b1;
      end
      if (deq_fire) begin
        rindex <= rindex + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_n.sv
// tb_fifo_n: directed-vector bench for fifo_n (DEPTH=4/WIDTH=96 instance plus a DEPTH=8/AFULL_LEVEL=2 instance).
// Expectations follow FIFO_N_FULL_PASS_EN when the bench is compiled with that macro.
module tb_fifo_n;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  // main instance, DEPTH=4
  logic        enq_ena;
  logic [95:0] enq_v;
  logic        enq_rdy;
  logic        deq_ena;
  logic        deq_rdy;
  logic [95:0] first;
  logic        first_rdy;
  logic [2:0]  count;
  logic        afull;

  // afull instance, DEPTH=8, AFULL_LEVEL=2
  logic        b_enq_ena;
  logic [15:0] b_enq_v;
  logic        b_enq_rdy;
  logic        b_deq_ena;
  logic        b_deq_rdy;
  logic [15:0] b_first;
  logic        b_first_rdy;
  logic [3:0]  b_count;
  logic        b_afull;

  fifo_n #(.WIDTH(96), .DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(enq_ena), .in_enq_v(enq_v), .in_enq__RDY(enq_rdy),
    .out_deq__ENA(deq_ena), .out_deq__RDY(deq_rdy),
    .out_first(first), .out_first__RDY(first_rdy),
    .status_count(count), .status_afull(afull)
  );

  fifo_n #(.WIDTH(16), .DEPTH(8), .AFULL_LEVEL(2)) dut8 (
    .CLK(CLK), .nRST(nRST),
    .in_enq__ENA(b_enq_ena), .in_enq_v(b_enq_v), .in_enq__RDY(b_enq_rdy),
    .out_deq__ENA(b_deq_ena), .out_deq__RDY(b_deq_rdy),
    .out_first(b_first), .out_first__RDY(b_first_rdy),
    .status_count(b_count), .status_afull(b_afull)
  );

  // ---------------- scoreboard ----------------
  logic [95:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
  task automatic step(input logic e, input logic [95:0] v, input logic d);
    enq_ena = e;
    enq_v   = v;
    deq_ena = d;
    @(posedge CLK);
    @(negedge CLK);
    enq_ena = 1'b0;
    deq_ena = 1'b0;
  endtask

  task automatic step_b(input logic e, input logic [15:0] v, input logic d);
    b_enq_ena = e;
    b_enq_v   = v;
    b_deq_ena = d;
    @(posedge CLK);
    @(negedge CLK);
    b_enq_ena = 1'b0;
    b_deq_ena = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check(tag, first, exp_q.pop_front());
      step(1'b0, '0, 1'b1);
    end
    check({tag, "_count"}, 96'(count), 96'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    enq_ena = 1'b0; enq_v = '0; deq_ena = 1'b0;
    b_enq_ena = 1'b0; b_enq_v = '0; b_deq_ena = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    // values held during power-on reset
    check("rst_count", 96'(count), 96'd0);
    check("rst_enq_rdy", 96'(enq_rdy), 96'd1);
    check("rst_deq_rdy", 96'(deq_rdy), 96'd0);
    check("rst_first_rdy", 96'(first_rdy), 96'd0);
    check("rst_first", first, 96'd0);
    check("rst_afull", 96'(afull), 96'd0);
    nRST = 1'b1;

    // fill and drain: 0xA..0xD, then 0xE dropped at full
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 96'(10 + i), 1'b0);
      exp_q.push_back(96'(10 + i));
    end
    check("fill_count", 96'(count), 96'd4);
    check("fill_afull", 96'(afull), 96'd1);
    check("fill_enq_rdy", 96'(enq_rdy), 96'd0);
    step(1'b1, 96'hE, 1'b0);
    check("drop_count", 96'(count), 96'd4);
    drain("drain");
    check("drain_deq_rdy", 96'(deq_rdy), 96'd0);

    // mid-clock reset pulse at count=3
    for (int i = 1; i <= 3; i++) step(1'b1, 96'(i), 1'b0);
    check("pre_rst_count", 96'(count), 96'd3);
    #2 nRST = 1'b0;
    #1;
    check("mid_rst_count", 96'(count), 96'd0);
    check("mid_rst_enq_rdy", 96'(enq_rdy), 96'd1);
    check("mid_rst_first_rdy", 96'(first_rdy), 96'd0);
    check("mid_rst_first", first, 96'd0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    step(1'b0, '0, 1'b1);
    check("post_rst_deq_count", 96'(count), 96'd0);
    check("post_rst_first_rdy", 96'(first_rdy), 96'd0);

    // simultaneous enq+deq at empty: only enq fires
    check("empty_deq_rdy", 96'(deq_rdy), 96'd0);
    step(1'b1, 96'h55, 1'b1);
    check("empty_both_count", 96'(count), 96'd1);
    check("empty_both_first", first, 96'h55);
    check("empty_both_first_rdy", 96'(first_rdy), 96'd1);
    step(1'b0, '0, 1'b1);
    check("empty_both_drain", 96'(count), 96'd0);

    // streaming at count=2, payloads 1..10, indices wrap
    step(1'b1, 96'h100, 1'b0);
    step(1'b1, 96'h101, 1'b0);
    exp_q.push_back(96'h100);
    exp_q.push_back(96'h101);
    for (int i = 1; i <= 10; i++) begin
      check("stream_first", first, exp_q.pop_front());
      exp_q.push_back(96'(i));
      step(1'b1, 96'(i), 1'b1);
      check("stream_count", 96'(count), 96'd2);
    end
    drain("stream_tail");

    // full with enq+deq together
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 96'(32 + i), 1'b0);
      exp_q.push_back(96'(32 + i));
    end
    enq_ena = 1'b1; enq_v = 96'h99; deq_ena = 1'b1;
    #1;
`ifdef FIFO_N_FULL_PASS_EN
    check("fullpass_enq_rdy", 96'(enq_rdy), 96'd1);
    step(1'b1, 96'h99, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(96'h99);
    check("fullpass_count", 96'(count), 96'd4);
`else
    check("fullpass_enq_rdy", 96'(enq_rdy), 96'd0);
    step(1'b1, 96'h99, 1'b1);
    void'(exp_q.pop_front());
    check("fullpass_count", 96'(count), 96'd3);
    check("after_full_enq_rdy", 96'(enq_rdy), 96'd1);
`endif
    drain("fullpass_drain");

    // afull on the DEPTH=8, AFULL_LEVEL=2 instance
    check("b_rst_afull", 96'(b_afull), 96'd0);
    step_b(1'b1, 16'h11, 1'b0);
    check("b_afull_at1", 96'(b_afull), 96'd0);
    b_enq_ena = 1'b1; b_enq_v = 16'h22;
    #1;
    check("b_afull_pre_edge", 96'(b_afull), 96'd0);
    step_b(1'b1, 16'h22, 1'b0);
    check("b_afull_rise", 96'(b_afull), 96'd1);
    check("b_count2", 96'(b_count), 96'd2);
    step_b(1'b0, '0, 1'b1);
    check("b_afull_fall", 96'(b_afull), 96'd0);
    check("b_first", 96'(b_first), 96'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_n.md
# fifo_n

Parametrised synchronous FIFO that replaces the fixed two-entry, 96-bit queue used between lpm pipeline stages. It uses all DEPTH entries (no sacrificial slot) and reports occupancy and an almost-full flag for upstream flow control. Both sides use the method-style ENA/RDY handshake: `in$enq` on the producer side, and `out$deq`/`out$first` on the consumer side. An optional build macro enables enqueue-while-full when a dequeue happens in the same cycle.

## Interface
- WIDTH, 96: payload width in bits; must be 1 or more.
- DEPTH, 4: number of entries; power of two, 2 or more.
- AFULL_LEVEL, DEPTH-1: occupancy at or above which `status$afull` asserts; range 1..DEPTH.
- CLK  in  1  clock; all state changes on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- in$enq__ENA  in  1  enqueue request.
- in$enq$v  in  WIDTH  enqueue payload.
- in$enq__RDY  out  1  enqueue may fire.
- out$deq__ENA  in  1  dequeue request.
- out$deq__RDY  out  1  dequeue may fire.
- out$first  out  WIDTH  head-entry payload.
- out$first__RDY  out  1  `out$first` is valid.
- status$count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- status$afull  out  1  count >= AFULL_LEVEL.

## Operation
- State:
  - storage array `mem[DEPTH]` of WIDTH bits.
  - `rindex` and `windex`, each $clog2(DEPTH) bits, wrapping naturally modulo DEPTH.
  - `count`, $clog2(DEPTH+1) bits.
- Fire conditions: enq fires = `in$enq__ENA & in$enq__RDY`; deq fires = `out$deq__ENA & out$deq__RDY`.
- On enq fire: `mem[windex] <= in$enq$v`; `windex <= windex+1`.
- On deq fire: `rindex <= rindex+1`.
- Count update: +1 on enq only, -1 on deq only, unchanged when both fire.
- Ready signals:
  - `out$deq__RDY = out$first__RDY = (count != 0)`.
  - `in$enq__RDY = (count != DEPTH)` by default; see Configuration.
- Data out: `out$first = mem[rindex]`, combinational. Its value is unspecified while `out$first__RDY` is 0, but it must not be X after reset.
- Ignored requests: an ENA with its RDY low has no effect; no error is flagged.
- Ordering: strict FIFO order. Payloads leave in the order accepted, with no duplication and no loss.

## Timing
- Reset:
  - Asserting nRST immediately clears `rindex`, `windex`, `count` and all `mem` entries, with no clock edge needed.
  - While reset is held, outputs are: `in$enq__RDY`=1, `out$deq__RDY`=0, `out$first__RDY`=0, `out$first`=0, `status$count`=0, `status$afull`=0.
  - Reset in the middle of traffic discards all contents.
  - The first enq can fire on the first rising edge after nRST deasserts.
- Latency: an entry enqueued at edge N is visible on `out$first`, with `out$first__RDY`=1, after edge N. Minimum fall-through latency is 1 cycle; there is no same-cycle bypass.
- Throughput: one enq and one deq per cycle are sustained at any occupancy from 1 to DEPTH-1.
- Empty boundary:
  - With count=0, deq is not ready.
  - A simultaneous enq+deq request performs the enq only; count becomes 1.
- Full boundary, macro off: with count=DEPTH, enq is not ready; a deq that fires makes enq ready in the next cycle.
- Wrap-around: indices wrap from DEPTH-1 to 0 with no bubble.
- Status outputs: `status$count` and `status$afull` are registered-state derived and change only on a clock edge.
- Timing paths: no combinational path from any ENA to any RDY, except `in$enq__RDY` when the macro is defined.

## Configuration
- `FIFO_N_FULL_PASS_EN` defined:
  - `in$enq__RDY = (count != DEPTH) | out$deq__ENA`.
  - When full, an enq and a deq in the same cycle both fire: the head is read out and the new payload is written into the slot just freed (`windex == rindex`). Count stays DEPTH.
  - Introduces a combinational path from `out$deq__ENA` to `in$enq__RDY`.
- Undefined: `in$enq__RDY = (count != DEPTH)`; it depends only on registered state.

## Test plan
- Reset check: pulse nRST low for 1 cycle, mid-clock, while count=3.
  - During reset: count=0, `in$enq__RDY`=1, `out$first__RDY`=0, `out$first`=0.
  - After reset: first deq attempt is ignored.
- Fill and drain, DEPTH=4, WIDTH=96:
  - Enq 0xA..0xD on consecutive cycles; count reaches 4, afull=1, `in$enq__RDY`=0.
  - A 5th enq of 0xE is dropped.
  - Drain returns 0xA, 0xB, 0xC, 0xD in order; count ends at 0.
- Streaming wrap: enq and deq every cycle at count=2 for 10 cycles with payloads 1..10. The output sequence is in order, count stays 2, and indices wrap twice.
- Simultaneous enq+deq at empty: count 0 → 1, and `out$first`=payload on the next cycle.
- Full pass:
  - At count=4 with enq+deq asserted:
    - Macro defined: both fire, count stays 4, and the new payload comes out 4 deqs later.
    - Macro undefined: only deq fires, count becomes 3.
- afull with AFULL_LEVEL=2, DEPTH=8: afull rises on the edge where count goes 1 → 2 and falls on the edge where count goes 2 → 1.
